// File: rtl/i2c_master_tx_pkg.sv
// Shared types and constants for the i2c_master_tx single-byte write controller.
// The NACK check is compiled in with I2C_MASTER_TX_ACK_CHECK_EN.
package i2c_master_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_START,
    S_ADDR,
    S_ACK1,
    S_DATA,
    S_ACK2,
    S_STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;

  // Ticks per complete write, and per write aborted on an address NACK
  localparam int FULL_TICKS = 80;
  localparam int NACK_TICKS = 44;

endpackage

// File: rtl/i2c_master_tx_if.sv
// Bus and handshake bundle between the I2C write controller and its surroundings.
// The master modport is the controller's view; slave is the environment's view.
interface i2c_master_tx_if;

  logic       baud_clk;
  logic       baud_en;
  logic       start;
  logic [6:0] addr;
  logic [7:0] data;
  logic       sda_in;
  logic       scl;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (
    input  baud_clk, start, addr, data, sda_in,
    output baud_en, scl, sda_oe, busy, done, ack_err
  );

  modport slave (
    output baud_clk, start, addr, data, sda_in,
    input  baud_en, scl, sda_oe, busy, done, ack_err
  );

endinterface

// File: rtl/i2c_master_tx_baud_tick_detect.sv
// Registers the baud generator clock and emits a one-clk pulse per rising edge.
module baud_tick_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic baud_clk,
  output logic tick
);

  logic baud_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q <= 1'b0;
    end else begin
      baud_q <= baud_clk;
    end
  end

  assign tick = baud_clk & ~baud_q;

endmodule

// File: rtl/i2c_master_tx.sv
// Single-transaction I2C write master: START, address+W, one data byte, STOP.
// Slave NACK detection is compiled in when I2C_MASTER_TX_ACK_CHECK_EN is defined.
module i2c_master_tx
  import i2c_master_tx_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  i2c_master_tx_if.master bus
);

  logic       tick;
  state_t     state, state_n;
  logic [1:0] phase, phase_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] data_q, data_q_n;
  logic       done_q, done_n;
  logic       ack_err_q, ack_err_n;
  logic       scl_c, sda_oe_c;

  baud_tick_detect u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_clk (bus.baud_clk),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= Q0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
      data_q    <= 8'd0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      data_q    <= data_q_n;
      done_q    <= done_n;
      ack_err_q <= ack_err_n;
    end
  end

  // state/phase name the quarter currently on the bus; a tick closes it
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    data_q_n  = data_q;
    done_n    = 1'b0;
    ack_err_n = ack_err_q;
    case (state)
      IDLE: begin
        if (bus.start && !done_q) begin
          state_n   = S_START;
          phase_n   = Q0;
          bit_cnt_n = 3'd0;
          shreg_n   = {bus.addr, RW_WRITE};
          data_q_n  = bus.data;
          ack_err_n = 1'b0;
        end
      end
      default: begin
        if (tick) begin
          phase_n = phase + 2'd1;
`ifdef I2C_MASTER_TX_ACK_CHECK_EN
          if ((state == S_ACK1 || state == S_ACK2) && phase == Q2 && bus.sda_in) begin
            ack_err_n = 1'b1;
          end
`endif
          if (phase == Q3) begin
            case (state)
              S_START: state_n = S_ADDR;
              S_ADDR, S_DATA: begin
                shreg_n   = {shreg[6:0], 1'b0};
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  state_n = (state == S_ADDR) ? S_ACK1 : S_ACK2;
                end
              end
              S_ACK1: begin
                state_n = S_DATA;
                shreg_n = data_q;
`ifdef I2C_MASTER_TX_ACK_CHECK_EN
                if (ack_err_q) begin
                  state_n = S_STOP;
                end
`endif
              end
              S_ACK2: state_n = S_STOP;
              S_STOP: begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
              default: state_n = IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Bus levels decode straight from state, so reset releases the bus asynchronously
  always_comb begin
    scl_c    = 1'b1;
    sda_oe_c = 1'b0;
    case (state)
      S_START: begin
        scl_c    = (phase != Q3);
        sda_oe_c = (phase == Q2) || (phase == Q3);
      end
      S_ADDR, S_DATA: begin
        scl_c    = (phase == Q2) || (phase == Q3);
        sda_oe_c = ~shreg[7];
      end
      S_ACK1, S_ACK2: begin
        scl_c = (phase == Q2) || (phase == Q3);
      end
      S_STOP: begin
        scl_c    = (phase != Q0);
        sda_oe_c = (phase == Q0) || (phase == Q1);
      end
      default: begin
      end
    endcase
  end

  assign bus.scl     = scl_c;
  assign bus.sda_oe  = sda_oe_c;
  assign bus.busy    = (state != IDLE);
  assign bus.baud_en = (state != IDLE);
  assign bus.done    = done_q;

`ifdef I2C_MASTER_TX_ACK_CHECK_EN
  assign bus.ack_err = ack_err_q;
`else
  logic unused_sda_in;
  assign unused_sda_in = bus.sda_in;
  assign bus.ack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_master_tx.sv
// Directed bench for i2c_master_tx: vector table of whole writes plus hand-built
// sequences for reset, overlapping START requests and DONE-coincident START.
module tb_i2c_master_tx;
  import i2c_master_tx_pkg::*;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       nack1;
    logic       nack2;
    int         hi;
    int         exp_ticks;
    logic       exp_err;
    int         exp_rises;
    logic [7:0] exp_abyte;
    logic [7:0] exp_dbyte;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  i2c_master_tx_if bus();

  i2c_master_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   rise_cnt = 0;
  int   rise_base = 0;
  int   start_cnt = 0;
  int   stop_cnt = 0;
  int   done_cnt = 0;
  int   busy_falls = 0;
  logic scl_prev = 1'b1;
  logic sda_prev = 1'b1;
  logic busy_prev = 1'b0;
  logic bits [1024];
  logic nack1_cur = 1'b0;
  logic nack2_cur = 1'b0;
  vec_t vecs [5];

  // Slave model: answers ACK1 on the 9th and ACK2 on the 18th SCL rise of a write
  assign bus.sda_in = ((rise_cnt - rise_base) == 9)  ? nack1_cur :
                      ((rise_cnt - rise_base) == 18) ? nack2_cur : 1'b1;

  // Bus monitor: bits seen on SCL rises, START/STOP conditions, DONE and BUSY edges
  always @(negedge clk) begin
    scl_prev  <= bus.scl;
    sda_prev  <= ~bus.sda_oe;
    busy_prev <= bus.busy;
    if (bus.scl && !scl_prev) begin
      bits[rise_cnt % 1024] <= ~bus.sda_oe;
      rise_cnt <= rise_cnt + 1;
    end
    if (bus.scl && scl_prev && sda_prev && bus.sda_oe) start_cnt <= start_cnt + 1;
    if (bus.scl && scl_prev && !sda_prev && !bus.sda_oe) stop_cnt <= stop_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (busy_prev && !bus.busy) busy_falls <= busy_falls + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] getByte(input int first);
    logic [7:0] b;
    b = 8'd0;
    for (int i = 0; i < 8; i++) b = {b[6:0], bits[(first + i) % 1024]};
    return b;
  endfunction

  task automatic applyTick(input int hi, input int lo);
    bus.baud_clk = 1'b1;
    repeat (hi) @(negedge clk);
    bus.baud_clk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic startTx(input logic [6:0] a, input logic [7:0] d);
    bus.addr = a;
    bus.data = d;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    int   n, s0, p0, d0;
    v = vecs[idx];
    nack1_cur = v.nack1;
    nack2_cur = v.nack2;
    rise_base = rise_cnt;
    s0 = start_cnt;
    p0 = stop_cnt;
    d0 = done_cnt;
    startTx(v.addr, v.data);
    checkOutput($sformatf("v%0d_busy_accept", idx), bus.busy, 1);
    checkOutput($sformatf("v%0d_baud_en", idx), bus.baud_en, 1);
    checkOutput($sformatf("v%0d_ack_err_clear", idx), bus.ack_err, 0);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      applyTick(v.hi, 2);
      n++;
    end
    checkOutput($sformatf("v%0d_ticks", idx), n, v.exp_ticks);
    checkOutput($sformatf("v%0d_busy_end", idx), bus.busy, 0);
    checkOutput($sformatf("v%0d_ack_err", idx), bus.ack_err, v.exp_err);
    checkOutput($sformatf("v%0d_rises", idx), rise_cnt - rise_base, v.exp_rises);
    checkOutput($sformatf("v%0d_addr_byte", idx), getByte(rise_base), v.exp_abyte);
    if (v.exp_rises == 19)
      checkOutput($sformatf("v%0d_data_byte", idx), getByte(rise_base + 9), v.exp_dbyte);
    checkOutput($sformatf("v%0d_start_cond", idx), start_cnt - s0, 1);
    checkOutput($sformatf("v%0d_stop_cond", idx), stop_cnt - p0, 1);
    checkOutput($sformatf("v%0d_done_pulses", idx), done_cnt - d0, 1);
  endtask

  initial begin
    int n, d0, f0;

    vecs[0] = '{7'h50, 8'hA5, 1'b0, 1'b0, 2, FULL_TICKS, 1'b0, 19, 8'hA0, 8'hA5};
`ifdef I2C_MASTER_TX_ACK_CHECK_EN
    vecs[1] = '{7'h50, 8'hA5, 1'b1, 1'b0, 2, NACK_TICKS, 1'b1, 10, 8'hA0, 8'h00};
    vecs[2] = '{7'h3C, 8'h5A, 1'b0, 1'b1, 2, FULL_TICKS, 1'b1, 19, 8'h78, 8'h5A};
`else
    vecs[1] = '{7'h50, 8'hA5, 1'b1, 1'b0, 2, FULL_TICKS, 1'b0, 19, 8'hA0, 8'hA5};
    vecs[2] = '{7'h3C, 8'h5A, 1'b0, 1'b1, 2, FULL_TICKS, 1'b0, 19, 8'h78, 8'h5A};
`endif
    vecs[3] = '{7'h7F, 8'h00, 1'b0, 1'b0, 2, FULL_TICKS, 1'b0, 19, 8'hFE, 8'h00};
    vecs[4] = '{7'h01, 8'hFF, 1'b0, 1'b0, 12, FULL_TICKS, 1'b0, 19, 8'h02, 8'hFF};

    bus.baud_clk = 1'b0;
    bus.start    = 1'b0;
    bus.addr     = 7'd0;
    bus.data     = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_scl", bus.scl, 1);
    checkOutput("reset_sda_oe", bus.sda_oe, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_baud_en", bus.baud_en, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_ack_err", bus.ack_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) applyStimulus(i);

    // Extra START at tick 20 with new ADDR/DATA, then START during the DONE cycle
    nack1_cur = 1'b0;
    nack2_cur = 1'b0;
    rise_base = rise_cnt;
    d0 = done_cnt;
    f0 = busy_falls;
    startTx(7'h50, 8'hA5);
    repeat (19) applyTick(2, 2);
    bus.start = 1'b1;
    bus.addr  = 7'h11;
    bus.data  = 8'h00;
    applyTick(2, 2);
    bus.start = 1'b0;
    repeat (59) applyTick(2, 2);
    checkOutput("ovl_busy_at_79", bus.busy, 1);
    bus.baud_clk = 1'b1;
    @(negedge clk);
    checkOutput("ovl_done_at_80", bus.done, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("ovl_start_with_done_ignored", bus.busy, 0);
    bus.baud_clk = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("ovl_still_idle", bus.busy, 0);
    checkOutput("ovl_busy_falls", busy_falls - f0, 1);
    checkOutput("ovl_done_pulses", done_cnt - d0, 1);
    checkOutput("ovl_addr_byte", getByte(rise_base), 8'hA0);
    checkOutput("ovl_data_byte", getByte(rise_base + 9), 8'hA5);

    // START raised in the DONE cycle and held one more cycle is accepted
    startTx(7'h2A, 8'h3C);
    repeat (79) applyTick(2, 2);
    bus.baud_clk = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    checkOutput("late_start_not_yet", bus.busy, 0);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("late_start_accepted", bus.busy, 1);
    rise_base = rise_cnt;
    d0 = done_cnt;
    bus.baud_clk = 1'b0;
    repeat (2) @(negedge clk);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      applyTick(2, 2);
      n++;
    end
    checkOutput("late_ticks", n, 80);
    checkOutput("late_addr_byte", getByte(rise_base), 8'h54);
    checkOutput("late_data_byte", getByte(rise_base + 9), 8'h3C);

    // Reset asserted mid-address must release the bus without a clock edge
    rise_base = rise_cnt;
    startTx(7'h50, 8'hA5);
    repeat (10) applyTick(2, 2);
    checkOutput("pre_reset_sda_oe", bus.sda_oe, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_scl", bus.scl, 1);
    checkOutput("async_reset_sda_oe", bus.sda_oe, 0);
    checkOutput("async_reset_busy", bus.busy, 0);
    checkOutput("async_reset_baud_en", bus.baud_en, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset_no_done", done_cnt - d0, 0);
    checkOutput("reset_stays_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
